// File: rtl/scfifo_pkg.sv
// Shared types for the single-clock FIFO controller: read-latency selector and registered flag bundle.
package scfifo_pkg;

  typedef enum logic {
    RD_LAT_1 = 1'b0,
    RD_LAT_2 = 1'b1
  } rd_lat_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic ovf;
    logic udf;
  } fifo_flags_t;

endpackage

// File: rtl/scfifo_rd_pipe.sv
// Delays accepted reads to line up RAM read enable and q_valid with the RAM's output timing.
module scfifo_rd_pipe
  import scfifo_pkg::*;
#(
  parameter int RAM_RD_LATENCY = 1
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic rd_acc_i,
  output logic ram_rd_en_o,
  output logic q_valid_o
);

  localparam rd_lat_e LAT = (RAM_RD_LATENCY == 2) ? RD_LAT_2 : RD_LAT_1;

  logic stage1_q, stage1_d;

  always_comb begin
    stage1_d = rd_acc_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) stage1_q <= 1'b0;
    else        stage1_q <= stage1_d;
  end

  generate
    if (LAT == RD_LAT_2) begin : g_lat2
      logic stage2_q, stage2_d;

      always_comb begin
        stage2_d = stage1_q;
      end

      always_ff @(posedge clk_i) begin
        if (srst_i) stage2_q <= 1'b0;
        else        stage2_q <= stage2_d;
      end

      // Output-register enable lags the address by one cycle; suppressed while in reset.
      assign ram_rd_en_o = stage1_q & ~srst_i;
      assign q_valid_o   = stage2_q;
    end else begin : g_lat1
      assign ram_rd_en_o = rd_acc_i;
      assign q_valid_o   = stage1_q;
    end
  endgenerate

endmodule

// File: rtl/scfifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy and flags for an external simple dual-port RAM.
// Handshake: a request is accepted in the cycle it is high unless blocked by full/empty or reset.
module scfifo_ctrl
  import scfifo_pkg::*;
#(
  parameter int AWIDTH             = 10,
  parameter int RAM_RD_LATENCY     = 1,
  parameter int ALMOST_FULL_VALUE  = 2**AWIDTH - 4,
  parameter int ALMOST_EMPTY_VALUE = 4
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [AWIDTH:0]   usedw_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              q_valid_o,
  output logic              ovf_o,
  output logic              udf_o,
  output logic              ram_wr_en_o,
  output logic [AWIDTH-1:0] ram_wr_addr_o,
  output logic              ram_rd_en_o,
  output logic [AWIDTH-1:0] ram_rd_addr_o
);

  localparam int              DEPTH   = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_W    = (AWIDTH+1)'(ALMOST_FULL_VALUE);
  localparam logic [AWIDTH:0] AE_W    = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
  localparam logic [AWIDTH:0] ONE     = (AWIDTH+1)'(1);
  localparam fifo_flags_t     FLAGS_RST = '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                                            almost_empty: 1'b1, ovf: 1'b0, udf: 1'b0};

  logic [AWIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0] usedw_q, usedw_d;
  fifo_flags_t     flags_q, flags_d;
  logic            wr_acc, rd_acc;

  always_comb begin
    wr_acc   = wrreq_i & ~flags_q.full  & ~srst_i;
    rd_acc   = rdreq_i & ~flags_q.empty & ~srst_i;
    wr_ptr_d = wr_acc ? wr_ptr_q + ONE : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + ONE : rd_ptr_q;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_d = usedw_q + ONE;
      2'b01:   usedw_d = usedw_q - ONE;
      default: usedw_d = usedw_q;
    endcase
    // Flags are registered off the next occupancy so they settle one cycle after the access.
    flags_d.full         = (usedw_d == DEPTH_W);
    flags_d.empty        = (usedw_d == '0);
    flags_d.almost_full  = (usedw_d >= AF_W);
    flags_d.almost_empty = (usedw_d < AE_W);
    flags_d.ovf          = wrreq_i & flags_q.full;
    flags_d.udf          = rdreq_i & flags_q.empty;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      flags_q  <= FLAGS_RST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      flags_q  <= flags_d;
    end
  end

  scfifo_rd_pipe #(
    .RAM_RD_LATENCY(RAM_RD_LATENCY)
  ) u_rd_pipe (
    .clk_i      (clk_i),
    .srst_i     (srst_i),
    .rd_acc_i   (rd_acc),
    .ram_rd_en_o(ram_rd_en_o),
    .q_valid_o  (q_valid_o)
  );

  assign usedw_o        = usedw_q;
  assign full_o         = flags_q.full;
  assign empty_o        = flags_q.empty;
  assign almost_full_o  = flags_q.almost_full;
  assign almost_empty_o = flags_q.almost_empty;
  assign ovf_o          = flags_q.ovf;
  assign udf_o          = flags_q.udf;
  assign ram_wr_en_o    = wr_acc;
  assign ram_wr_addr_o  = wr_ptr_q[AWIDTH-1:0];
  assign ram_rd_addr_o  = rd_ptr_q[AWIDTH-1:0];

endmodule
